// File: rtl/agc_monitor_injector.sv
// Monitor-bus word injector: FIFO-buffered words driven onto MDT during an MT window.
// Optional MONPAR odd-parity drive is built when MDT_PARITY_EN is defined.
module agc_monitor_injector #(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_START     = 1,
  parameter int T_END       = 12,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          SIM_CLK,
  input  logic                          SIM_RST,
  input  logic [15:0]                   wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [11:0]                   mt,
  input  logic                          MGOJAM,
  output logic [15:0]                   mdt,
  output logic                          mdt_drive,
  output logic                          done,
  output logic                          err_timeout,
  output logic                          err_gojam,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          MONPAR
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRIVE,
    S_HOLD
  } state_e;

  state_e          state_q;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [TW-1:0]   cnt_q;
  logic [11:0]     mt_q;
  logic [15:0]     mdt_q;
  logic            drive_q;
  logic            done_q;
  logic            to_q;
  logic            gj_q;

  logic            rise;
  logic            fall;
  logic            to_hit;
  logic            push;
  logic            pop;
  logic            load;
  logic            clear;
  logic [15:0]     head;
  logic            unused_mt;

  assign rise   = mt[T_START-1] & ~mt_q[T_START-1];
  assign fall   = ~mt[T_END-1] & mt_q[T_END-1];
  assign to_hit = (cnt_q == TO_LAST);
  assign head   = mem_q[rd_ptr_q];

  assign wr_ready = (count_q != FULL);
  assign push     = wr_valid & wr_ready;

  // GOJAM outranks rise, fall and timeout in every active state
  assign load  = (state_q == S_WAIT) & ~MGOJAM & rise;
  assign clear = (state_q == S_DRIVE) & (MGOJAM | fall);
  assign pop   = ((state_q == S_WAIT) & ~MGOJAM & ~rise & to_hit)
               | ((state_q == S_DRIVE) & ~MGOJAM & fall);

  assign unused_mt = ^{mt, mt_q};

  // Occupancy next value for simultaneous push/pop
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Word buffer: circular storage with wrapping pointers
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Previous MT sample for edge detection
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) mt_q <= '0;
    else         mt_q <= mt;
  end

  // Window sequencer with registered bus drive and status pulses
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mdt_q   <= '0;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      gj_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      to_q   <= 1'b0;
      gj_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|count_q) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end
        end
        S_WAIT: begin
          if (MGOJAM) begin
            state_q <= S_HOLD;
            gj_q    <= 1'b1;
          end else if (rise) begin
            state_q <= S_DRIVE;
            mdt_q   <= head;
            drive_q <= 1'b1;
          end else if (to_hit) begin
            state_q <= S_IDLE;
            to_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRIVE: begin
          if (MGOJAM) begin
            state_q <= S_HOLD;
            mdt_q   <= '0;
            drive_q <= 1'b0;
            gj_q    <= 1'b1;
          end else if (fall) begin
            state_q <= S_IDLE;
            mdt_q   <= '0;
            drive_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!MGOJAM) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MDT_PARITY_EN
  logic par_q;

  // Odd parity over MDT01..MDT15, loaded and cleared alongside mdt
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST)    par_q <= 1'b0;
    else if (load)  par_q <= ~^head[14:0];
    else if (clear) par_q <= 1'b0;
  end

  assign MONPAR = par_q;
`else
  assign MONPAR = 1'b0;
`endif

  assign mdt         = mdt_q;
  assign mdt_drive   = drive_q;
  assign done        = done_q;
  assign err_timeout = to_q;
  assign err_gojam   = gj_q;
  assign fifo_count  = count_q;

endmodule
